spi_image_loader: RTL and testbench
===================================

Name: spi_image_loader

Overview:
Consumes bytes from the SPI byte receiver and parses a simple command stream. On a LOAD command it assembles a fixed-size bit-packed binary image. It presents the image to the BNN inference core with a valid/ack handshake and throttles the SPI receiver, via `rx_enable`, while the image is held.

Parameters:
- IMG_W, 10, image width in pixels
- IMG_H, 10, image height in pixels
- IMG_BITS, IMG_W*IMG_H (100), pixel bits per image (derived)
- IMG_BYTES, ceil(IMG_BITS/8) (13), payload bytes per image (derived)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_rx_data  in  8  received byte from SPI receiver
- byte_valid  in  1  level; byte on `spi_rx_data` is valid
- byte_taken  out  1  one-cycle pulse acknowledging the byte
- rx_enable  out  1  permits SPI receiver to capture
- img_data  out  IMG_BITS  assembled image, bit 0 = first pixel
- img_valid  out  1  image complete and stable
- img_ack  in  1  inference core has consumed the image
- cmd_error  out  1  sticky; unknown command byte seen (cleared by CLEAR cmd)
- bytes_rcvd  out  4  payload byte index of the current load

Behaviour:
- Reset values:
  - state IDLE; `byte_taken`=0; `rx_enable`=1; `img_data`=0; `img_valid`=0; `cmd_error`=0; `bytes_rcvd`=0.
  - Reset mid-load discards the partial image.
- Commands (first byte of a transaction, accepted in IDLE):
  - LOAD=8'hA5: go to LOAD, `bytes_rcvd`<=0.
  - CLEAR=8'hC3: `img_data`<=0 and `cmd_error`<=0; stay in IDLE.
  - Any other value: `cmd_error`<=1; stay in IDLE.
- Byte-take handshake:
  - Byte accepted when `byte_valid`=1 and the internal `armed`=1.
  - On accept: `byte_taken` pulses high for exactly 1 cycle, and `armed`<=0.
  - `armed`<=1 only after `byte_valid` is sampled low. This prevents double-taking, because the upstream `byte_valid` is registered and stays high one cycle after the take.
  - `armed` resets to 1.
- FSM:
  - IDLE: parse command bytes as above.
  - LOAD: each accepted byte k writes `img_data[8k +: 8]`, then `bytes_rcvd`<=k+1.
    - Last byte (k=IMG_BYTES-1): only the low IMG_BITS-8k bits are written (4 bits at default); the rest of the byte is dropped.
    - After the last byte: `img_valid`<=1 in the cycle after the accept; go to READY.
  - READY: `img_valid`=1; `rx_enable`=0; `img_data` held constant; `byte_valid` ignored (no `byte_taken`).
    - On `img_ack`=1: `img_valid`<=0 and `rx_enable`<=1 next cycle; go to IDLE.
    - `img_ack` in any other state is ignored.
- Register, not full overwrite: a new LOAD overwrites the image byte by byte. `img_data` is meaningful only while `img_valid`=1.
- `byte_valid` high and `img_ack` high in the same cycle in READY: the ack wins, and the byte is left for IDLE to accept once `armed` allows.
- `rx_enable` is registered; deassertion takes effect the cycle after READY is entered.
- No timeout. A stalled LOAD waits indefinitely, and only reset aborts it.

Decomposition:
- Shared package `spi_img_pkg`: command constants CMD_LOAD and CMD_CLEAR, the state enum (IDLE, LOAD, READY), and IMG_W/IMG_H defaults.
- One natural sub-module, `byte_take_ctrl`: `armed` flag plus `byte_taken` pulse generation. It is reusable by other byte consumers.

Test Plan:
- Reset, then CLEAR (8'hC3) -> `img_data`=0, `cmd_error`=0, one `byte_taken` pulse, `img_valid` stays 0.
- LOAD + 13 bytes 8'h01..8'h0D (last byte 8'hFD) -> `img_data[7:0]`=8'h01, `img_data[95:88]`=8'h0C, `img_data[99:96]`=4'hD; `img_valid`=1 one cycle after the 13th take; exactly 14 `byte_taken` pulses.
- `byte_valid` held high 3 cycles per byte -> exactly one `byte_taken` per byte; no skipped or duplicated bytes.
- In READY: `byte_valid` asserted -> no `byte_taken`, `rx_enable`=0. Then `img_ack` pulse -> `img_valid`=0 and `rx_enable`=1 next cycle; the pending byte is taken in IDLE.
- Command 8'h55 -> `cmd_error`=1, state stays IDLE. A subsequent CLEAR -> `cmd_error`=0.
- Reset asserted after 6 payload bytes -> all outputs at reset values. A new LOAD of 13 bytes then completes normally.

Source files
------------

// File: rtl/spi_img_pkg.sv
// Shared definitions for the SPI image loader: command bytes, FSM states
// and default image geometry.
package spi_img_pkg;

  localparam int IMG_W_DEFAULT = 10;
  localparam int IMG_H_DEFAULT = 10;

  localparam logic [7:0] CMD_LOAD  = 8'hA5;
  localparam logic [7:0] CMD_CLEAR = 8'hC3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Whole bytes needed to carry a given number of pixel bits.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/byte_take_ctrl.sv
// Single-take byte handshake for a consumer of a registered byte stream.
//
// Handshake: a byte is accepted in a cycle where byte_valid_i=1, the
// controller is armed and the consumer asserts enable_i. accept_o is the
// combinational strobe the consumer uses to capture the byte at that edge;
// byte_taken_o is the registered one-cycle acknowledge back to the producer.
// After an accept the controller disarms and re-arms only once byte_valid_i
// is seen low, so a producer whose valid lingers one cycle after the
// acknowledge is never taken twice.
module byte_take_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic byte_valid_i,
  input  logic enable_i,
  output logic accept_o,
  output logic byte_taken_o
);

  logic armed_q;
  logic taken_q;

  assign accept_o     = byte_valid_i & armed_q & enable_i;
  assign byte_taken_o = taken_q;

  // Arm/disarm tracking and registered acknowledge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      taken_q <= 1'b0;
    end else begin
      taken_q <= accept_o;
      if (accept_o) begin
        armed_q <= 1'b0;
      end else if (!byte_valid_i) begin
        armed_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_image_loader.sv
// Parses a command byte stream from the SPI receiver, assembles a
// bit-packed binary image on LOAD and holds it for the inference core
// until acknowledged, throttling the receiver meanwhile.
module spi_image_loader
  import spi_img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               spi_rx_data,
  input  logic                     byte_valid,
  output logic                     byte_taken,
  output logic                     rx_enable,
  output logic [IMG_W*IMG_H-1:0]   img_data,
  output logic                     img_valid,
  input  logic                     img_ack,
  output logic                     cmd_error,
  output logic [3:0]               bytes_rcvd,
  output logic [1:0]               dbg_state_o
);

  localparam int         IMG_BITS  = IMG_W * IMG_H;
  localparam int         IMG_BYTES = bytes_for_bits(IMG_BITS);
  localparam logic [3:0] LAST_IDX  = 4'(IMG_BYTES - 1);

  state_e              state_q;
  logic [3:0]          bytes_rcvd_q;
  logic [IMG_BITS-1:0] img_data_q;
  logic [IMG_BITS-1:0] img_data_d;
  logic                img_valid_q;
  logic                rx_enable_q;
  logic                cmd_error_q;
  logic                accept;

  // Bytes are never taken while an image is being held.
  byte_take_ctrl u_take (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (byte_valid),
    .enable_i     (state_q != ST_READY),
    .accept_o     (accept),
    .byte_taken_o (byte_taken)
  );

  // Image with the incoming byte merged at the current payload index.
  // Bits beyond IMG_BITS do not exist, so the unused high part of the
  // final byte falls away naturally.
  for (genvar j = 0; j < IMG_BITS; j++) begin : g_bit
    assign img_data_d[j] = (bytes_rcvd_q == 4'(j / 8)) ? spi_rx_data[j % 8]
                                                      : img_data_q[j];
  end

  // Command/load/hold state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bytes_rcvd_q <= 4'd0;
      img_data_q   <= '0;
      img_valid_q  <= 1'b0;
      rx_enable_q  <= 1'b1;
      cmd_error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (spi_rx_data == CMD_LOAD) begin
              state_q      <= ST_LOAD;
              bytes_rcvd_q <= 4'd0;
            end else if (spi_rx_data == CMD_CLEAR) begin
              img_data_q  <= '0;
              cmd_error_q <= 1'b0;
            end else begin
              cmd_error_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            img_data_q   <= img_data_d;
            bytes_rcvd_q <= bytes_rcvd_q + 4'd1;
            if (bytes_rcvd_q == LAST_IDX) begin
              state_q     <= ST_READY;
              img_valid_q <= 1'b1;
            end
          end
        end
        ST_READY: begin
          // The receiver is throttled one cycle after READY is entered.
          if (img_ack) begin
            img_valid_q <= 1'b0;
            rx_enable_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            rx_enable_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_enable   = rx_enable_q;
  assign img_data    = img_data_q;
  assign img_valid   = img_valid_q;
  assign cmd_error   = cmd_error_q;
  assign bytes_rcvd  = bytes_rcvd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_image_loader.sv
// Directed bench for spi_image_loader: a vector table for the main LOAD
// stream plus hand-written sequences for READY hold, command errors and
// reset in the middle of a load.
module tb_spi_image_loader;
  import spi_img_pkg::*;

  localparam int BITS = 100;

  logic            clk;
  logic            rst_n;
  logic [7:0]      spi_rx_data;
  logic            byte_valid;
  logic            byte_taken;
  logic            rx_enable;
  logic [BITS-1:0] img_data;
  logic            img_valid;
  logic            img_ack;
  logic            cmd_error;
  logic [3:0]      bytes_rcvd;
  logic [1:0]      dbg_state;

  int vectors;
  int miscompares;
  int taken_cnt;

  spi_image_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_rx_data (spi_rx_data),
    .byte_valid  (byte_valid),
    .byte_taken  (byte_taken),
    .rx_enable   (rx_enable),
    .img_data    (img_data),
    .img_valid   (img_valid),
    .img_ack     (img_ack),
    .cmd_error   (cmd_error),
    .bytes_rcvd  (bytes_rcvd),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every acknowledge pulse, sampled away from the active edge.
  initial taken_cnt = 0;
  always @(negedge clk) if (byte_taken === 1'b1) taken_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called just after a rising edge. Presents a byte, waits (bounded) for
  // the acknowledge, keeps valid high for 'hold' more edges as a registered
  // producer would, then drops valid for one edge so the loader re-arms.
  task automatic send_byte(input logic [7:0] b, input int hold, output logic vld_at_take);
    int n = 0;
    spi_rx_data = b;
    byte_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (byte_taken !== 1'b1 && n < 20);
    check("byte_taken_seen", byte_taken, 1);
    vld_at_take = img_valid;
    repeat (hold) @(posedge clk);
    #1 byte_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},      dbg_state,  ST_IDLE);
    check({tag, "_byte_taken"}, byte_taken, 0);
    check({tag, "_rx_enable"},  rx_enable,  1);
    check({tag, "_img_data"},   img_data,   0);
    check({tag, "_img_valid"},  img_valid,  0);
    check({tag, "_cmd_error"},  cmd_error,  0);
    check({tag, "_bytes_rcvd"}, bytes_rcvd, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    int         hold;
    logic [1:0] exp_state;
    logic [3:0] exp_cnt;
    logic       exp_vld;
    logic       exp_rx_en;
  } vec_t;

  vec_t tbl[14];

  logic [BITS-1:0] exp_img;
  logic [BITS-1:0] exp_img2;
  logic            v;
  int              c0;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    spi_rx_data = 8'h00;
    byte_valid  = 1'b0;
    img_ack     = 1'b0;

    // LOAD then payload 01..0C and FD; holds vary 1..3 extra edges.
    tbl[0] = '{8'hA5, 1, ST_LOAD, 4'd0, 1'b0, 1'b1};
    for (int k = 1; k <= 13; k++) begin
      tbl[k].data      = (k == 13) ? 8'hFD : 8'(k);
      tbl[k].hold      = 1 + (k % 3);
      tbl[k].exp_state = (k == 13) ? ST_READY : ST_LOAD;
      tbl[k].exp_cnt   = 4'(k);
      tbl[k].exp_vld   = (k == 13);
      tbl[k].exp_rx_en = (k != 13);
    end

    exp_img = '0;
    for (int k = 0; k < 12; k++) exp_img[8*k +: 8] = 8'(k + 1);
    exp_img[99:96] = 4'hD;

    exp_img2 = '0;
    for (int k = 0; k < 12; k++) exp_img2[8*k +: 8] = 8'(8'h30 + k);
    exp_img2[99:96] = 4'h7;

    // Reset state.
    do_reset();
    check_reset_values("rst");

    // Unknown command sets the sticky error and stays idle.
    send_byte(8'h55, 1, v);
    check("err_cmd_error", cmd_error, 1);
    check("err_state", dbg_state, ST_IDLE);

    // img_ack outside READY is ignored.
    img_ack = 1'b1;
    @(posedge clk);
    #1 img_ack = 1'b0;
    check("ack_idle_state", dbg_state, ST_IDLE);
    check("ack_idle_rx_en", rx_enable, 1);

    // CLEAR: one take, error cleared, image zero, no valid.
    c0 = taken_cnt;
    send_byte(CMD_CLEAR, 1, v);
    check("clr_takes", taken_cnt - c0, 1);
    check("clr_cmd_error", cmd_error, 0);
    check("clr_img_data", img_data, 0);
    check("clr_img_valid", img_valid, 0);

    // Main LOAD stream from the table.
    c0 = taken_cnt;
    for (int i = 0; i < 14; i++) begin
      send_byte(tbl[i].data, tbl[i].hold, v);
      check($sformatf("v%0d_vld_at_take", i), v, tbl[i].exp_vld);
      check($sformatf("v%0d_state", i), dbg_state, tbl[i].exp_state);
      check($sformatf("v%0d_bytes_rcvd", i), bytes_rcvd, tbl[i].exp_cnt);
      check($sformatf("v%0d_img_valid", i), img_valid, tbl[i].exp_vld);
      check($sformatf("v%0d_rx_enable", i), rx_enable, tbl[i].exp_rx_en);
    end
    check("load_takes", taken_cnt - c0, 14);
    check("load_img_data", img_data, exp_img);

    // READY: a pending CLEAR byte is ignored and the image is held.
    spi_rx_data = CMD_CLEAR;
    byte_valid  = 1'b1;
    c0 = taken_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("ready_no_take", taken_cnt - c0, 0);
    check("ready_rx_enable", rx_enable, 0);
    check("ready_img_valid", img_valid, 1);
    check("ready_img_held", img_data, exp_img);

    // Ack with byte_valid still high: ack wins, byte taken next in IDLE.
    img_ack = 1'b1;
    @(posedge clk);
    #1 img_ack = 1'b0;
    check("ack_img_valid", img_valid, 0);
    check("ack_rx_enable", rx_enable, 1);
    check("ack_state", dbg_state, ST_IDLE);
    check("ack_no_take_yet", byte_taken, 0);
    @(posedge clk);
    #1;
    check("pending_taken", byte_taken, 1);
    check("pending_clear", img_data, 0);
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pending_single", taken_cnt - c0, 1);

    // Reset in the middle of a load discards the partial image.
    send_byte(CMD_LOAD, 1, v);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h20 + k), 1, v);
    check("mid_bytes_rcvd", bytes_rcvd, 6);
    check("mid_state", dbg_state, ST_LOAD);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh load after the abort completes normally.
    c0 = taken_cnt;
    send_byte(CMD_LOAD, 1, v);
    for (int k = 0; k < 12; k++) send_byte(8'(8'h30 + k), 1, v);
    send_byte(8'hE7, 1, v);
    check("reload_vld_at_take", v, 1);
    check("reload_takes", taken_cnt - c0, 14);
    check("reload_img_data", img_data, exp_img2);
    check("reload_img_valid", img_valid, 1);
    check("reload_bytes_rcvd", bytes_rcvd, 13);
    check("reload_rx_enable", rx_enable, 0);

    img_ack = 1'b1;
    @(posedge clk);
    #1 img_ack = 1'b0;
    check("reload_ack_valid", img_valid, 0);
    check("reload_ack_state", dbg_state, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
